// File: rtl/rsfq_merge_pkg.sv
// ---------------------------------------------------------------------------
// rsfq_merge_pkg
//   Shared constants and helpers for the RSFQ merge arbiter.
//   - N_REQ_DEF / CNT_W_DEF / MIN_GAP_DEF : default block parameters
//   - cnt_max()  : saturation value of a CNT_W-bit pending-pulse counter
//   - rr_pick()  : one-hot round-robin winner, search starts at ptr+1 mod n
// ---------------------------------------------------------------------------
package rsfq_merge_pkg;

   localparam int N_REQ_DEF   = 4;
   localparam int CNT_W_DEF   = 3;
   localparam int MIN_GAP_DEF = 2;

   // rr_pick works on a fixed-width vector so one function serves any N_REQ
   // up to RR_MAX; callers zero-extend their request vector.
   localparam int RR_MAX   = 32;
   localparam int RR_IDX_W = 5;

   function automatic int cnt_max(input int cnt_w);
      return (1 << cnt_w) - 1;
   endfunction

   function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                 input int               n,
                                                 input int               ptr);
      logic [RR_MAX-1:0]   g;
      logic [RR_IDX_W-1:0] sel;
      int                  idx;
      g   = '0;
      sel = '0;
      idx = 0;
      // First set bit at or after ptr+1, wrapping; ptr itself is visited last.
      for (int k = 1; k <= RR_MAX; k++) begin
         if (k <= n && g == '0) begin
            idx = (ptr + k) % n;
            sel = idx[RR_IDX_W-1:0];
            if (req[sel]) g[sel] = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/rsfq_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rsfq_rr_arbiter
//   Combinational round-robin arbiter.
//   Ports:
//     req        in   N_REQ   requesters asking for the output this cycle
//     ptr        in   PTR_W   last winner; search starts at ptr+1
//     grant      out  N_REQ   one-hot winner (all zero when no request)
//     grant_idx  out  PTR_W   index of the winner (0 when none)
//     grant_vld  out  1       a winner exists
// ---------------------------------------------------------------------------
module rsfq_rr_arbiter
   import rsfq_merge_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PTR_W-1:0] grant_idx,
   output logic             grant_vld
);

   logic [RR_MAX-1:0] req_wide;
   logic [RR_MAX-1:0] pick;
   logic              unused_pick;

   always_comb begin
      req_wide             = '0;
      req_wide[N_REQ-1:0] = req;
      pick                 = rr_pick(req_wide, N_REQ, int'(ptr));
      grant                = pick[N_REQ-1:0];
      grant_vld            = |pick[N_REQ-1:0];
      grant_idx            = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick[i]) grant_idx = PTR_W'(i);
      end
   end

   // Bits above N_REQ can never be set; fold them away.
   assign unused_pick = ^pick;

endmodule

// File: rtl/rsfq_merge_arbiter.sv
// ---------------------------------------------------------------------------
// rsfq_merge_arbiter
//   Counts every toggle-encoded SFQ pulse from N_REQ requesters and replays
//   them one at a time, round-robin, on a single toggle-encoded output with
//   at least MIN_GAP clocks between output toggles.
//   Ports:
//     clk      in   1      clock, all state on posedge
//     rst      in   1      asynchronous, active-high reset
//     req_t    in   N_REQ  toggle-encoded requester inputs (sync to clk)
//     ovf_clr  in   1      clears all sticky overflow flags
//     q        out  1      toggle-encoded merged output
//     pending  out  N_REQ  requester i has queued pulses
//     ovf      out  N_REQ  sticky: requester i lost a pulse to saturation
//     busy     out  1      pulses queued or gap timer still running
// ---------------------------------------------------------------------------
module rsfq_merge_arbiter
   import rsfq_merge_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int MIN_GAP = MIN_GAP_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_t,
   input  logic             ovf_clr,
   output logic             q,
   output logic [N_REQ-1:0] pending,
   output logic [N_REQ-1:0] ovf,
   output logic             busy
);

   localparam int              PTR_W    = $clog2(N_REQ);
   localparam int              GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);

   logic [N_REQ-1:0] req_q;
   logic [CNT_W-1:0] cnt [N_REQ];
   logic [GAP_W-1:0] gap;
   logic [PTR_W-1:0] ptr;

   logic [N_REQ-1:0] pulse;
   logic [N_REQ-1:0] arb_req;
   logic [N_REQ-1:0] grant;
   logic [PTR_W-1:0] grant_idx;
   logic             grant_vld;
   logic [N_REQ-1:0] ovf_hit;

   // Saturating counter step: a pulse and a grant in the same cycle cancel,
   // and a pulse arriving on a full counter is dropped (flagged via ovf_hit).
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                 input logic             inc,
                                                 input logic             dec);
      case ({inc, dec})
         2'b10:   return (c == CNT_MAX) ? c : c + CNT_W'(1);
         2'b01:   return c - CNT_W'(1);
         default: return c;
      endcase
   endfunction

   assign pulse = req_t ^ req_q;

   always_comb begin
      pending = '0;
      ovf_hit = '0;
      for (int i = 0; i < N_REQ; i++) begin
         pending[i] = (cnt[i] != '0);
         ovf_hit[i] = pulse[i] & ~grant[i] & (cnt[i] == CNT_MAX);
      end
   end

   // Only registered counters compete, so a pulse is never replayed in the
   // same cycle it is detected.
   assign arb_req = pending & {N_REQ{gap == '0}};
   assign busy    = (|pending) | (gap != '0);

   rsfq_rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req       (arb_req),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // ---- registered state: edge history, counters, timer, output toggle ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q <= '0;
         q     <= 1'b0;
         gap   <= '0;
         ptr   <= PTR_W'(N_REQ - 1);
         ovf   <= '0;
         for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
      end else begin
         req_q <= req_t;
         for (int i = 0; i < N_REQ; i++) cnt[i] <= cnt_next(cnt[i], pulse[i], grant[i]);
         // A fresh overflow overrides a simultaneous clear.
         ovf <= (ovf_clr ? '0 : ovf) | ovf_hit;
         if (grant_vld) begin
            q   <= ~q;
            ptr <= grant_idx;
            gap <= GAP_LOAD;
         end else if (gap != '0) begin
            gap <= gap - GAP_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_rsfq_merge_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rsfq_merge_arbiter
//   Directed bench: dut (MIN_GAP=2) for the table, saturation, reset and
//   random conservation runs; dut1 (MIN_GAP=1) for back-to-back pulses.
// ---------------------------------------------------------------------------
module tb_rsfq_merge_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req_t = '0;
   logic [3:0] req1_t = '0;
   logic       ovf_clr = 1'b0;
   logic       ovf1_clr = 1'b0;
   logic       q, q1, busy, busy1;
   logic [3:0] pending, ovf, pending1, ovf1;

   int   checks = 0;
   int   failures = 0;
   int   tog_cnt = 0;
   int   gap_viol = 0;
   int   since = 1000;
   logic q_prev = 1'b0;

   rsfq_merge_arbiter #(.N_REQ(4), .CNT_W(3), .MIN_GAP(2)) dut (
      .clk(clk), .rst(rst), .req_t(req_t), .ovf_clr(ovf_clr),
      .q(q), .pending(pending), .ovf(ovf), .busy(busy));

   rsfq_merge_arbiter #(.N_REQ(4), .CNT_W(3), .MIN_GAP(1)) dut1 (
      .clk(clk), .rst(rst), .req_t(req1_t), .ovf_clr(ovf1_clr),
      .q(q1), .pending(pending1), .ovf(ovf1), .busy(busy1));

   always #5 clk = ~clk;

   // Output toggle monitor for dut: counts toggles, records spacing violations.
   always @(negedge clk) begin
      if (rst) begin
         q_prev = 1'b0;
         since  = 1000;
      end else begin
         since++;
         if (q !== q_prev) begin
            tog_cnt++;
            if (since < 2) gap_viol++;
            since = 0;
         end
         q_prev = q;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_idle(input int lim, output bit ok);
      for (int i = 0; i < lim; i++) begin
         if (busy === 1'b0) break;
         step();
      end
      ok = (busy === 1'b0);
   endtask

   typedef struct packed {
      logic [3:0] req_t;
      logic       q;
      logic [3:0] pend;
      logic       busy;
   } vec_t;

   vec_t vecs [33];

   function automatic vec_t v(input logic [3:0] r, input logic qq,
                              input logic [3:0] p, input logic b);
      vec_t x;
      x.req_t = r; x.q = qq; x.pend = p; x.busy = b;
      return x;
   endfunction

   initial begin
      bit         ok;
      int         base;
      int         pulses;
      logic [3:0] chg;
      logic [4:0] t3_q = 5'b11010;
      logic [4:0] t3_b = 5'b00111;

      // simultaneous pulses on all four, replayed 0,1,2,3 two clocks apart
      vecs[0]  = v(4'b0000, 0, 4'b0000, 0);
      vecs[1]  = v(4'b1111, 0, 4'b1111, 1);
      vecs[2]  = v(4'b1111, 1, 4'b1110, 1);
      vecs[3]  = v(4'b1111, 1, 4'b1110, 1);
      vecs[4]  = v(4'b1111, 0, 4'b1100, 1);
      vecs[5]  = v(4'b1111, 0, 4'b1100, 1);
      vecs[6]  = v(4'b1111, 1, 4'b1000, 1);
      vecs[7]  = v(4'b1111, 1, 4'b1000, 1);
      vecs[8]  = v(4'b1111, 0, 4'b0000, 1);
      vecs[9]  = v(4'b1111, 0, 4'b0000, 0);
      // pulse coinciding with a grant leaves the counter unchanged
      vecs[10] = v(4'b1110, 0, 4'b0001, 1);
      vecs[11] = v(4'b1111, 1, 4'b0001, 1);
      vecs[12] = v(4'b1111, 1, 4'b0001, 1);
      vecs[13] = v(4'b1111, 0, 4'b0000, 1);
      vecs[14] = v(4'b1111, 0, 4'b0000, 0);
      // pointer at 0: requester 3 wins before 0
      vecs[15] = v(4'b0110, 0, 4'b1001, 1);
      vecs[16] = v(4'b0110, 1, 4'b0001, 1);
      vecs[17] = v(4'b0110, 1, 4'b0001, 1);
      vecs[18] = v(4'b0110, 0, 4'b0000, 1);
      vecs[19] = v(4'b0110, 0, 4'b0000, 0);
      // fairness: 3 pulses each on 0 and 3, grants alternate 3,0,3,0,3,0
      vecs[20] = v(4'b1111, 0, 4'b1001, 1);
      vecs[21] = v(4'b0110, 1, 4'b1001, 1);
      vecs[22] = v(4'b1111, 1, 4'b1001, 1);
      vecs[23] = v(4'b1111, 0, 4'b1001, 1);
      vecs[24] = v(4'b1111, 0, 4'b1001, 1);
      vecs[25] = v(4'b1111, 1, 4'b1001, 1);
      vecs[26] = v(4'b1111, 1, 4'b1001, 1);
      vecs[27] = v(4'b1111, 0, 4'b1001, 1);
      vecs[28] = v(4'b1111, 0, 4'b1001, 1);
      vecs[29] = v(4'b1111, 1, 4'b0001, 1);
      vecs[30] = v(4'b1111, 1, 4'b0001, 1);
      vecs[31] = v(4'b1111, 0, 4'b0000, 1);
      vecs[32] = v(4'b1111, 0, 4'b0000, 0);

      // reset state
      step();
      step();
      chk("rst_q", q, 0);
      chk("rst_pending", pending, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_busy", busy, 0);
      chk("rst1_q", q1, 0);
      chk("rst1_busy", busy1, 0);
      rst = 1'b0;

      for (int k = 0; k < 33; k++) begin
         req_t = vecs[k].req_t;
         step();
         chk($sformatf("vec%0d_q", k), q, vecs[k].q);
         chk($sformatf("vec%0d_pending", k), pending, vecs[k].pend);
         chk($sformatf("vec%0d_busy", k), busy, vecs[k].busy);
         chk($sformatf("vec%0d_ovf", k), ovf, 0);
      end

      // saturation: 20 back-to-back pulses on requester 0, 3 dropped
      base = tog_cnt;
      for (int k = 0; k < 20; k++) begin
         req_t[0] = ~req_t[0];
         ovf_clr  = (k == 15 || k == 16);
         step();
         if (k == 13) chk("sat_ovf_before", ovf, 4'b0000);
         if (k == 14) chk("sat_ovf_set", ovf, 4'b0001);
         if (k == 15) chk("sat_ovf_clr", ovf, 4'b0000);
         if (k == 16) chk("sat_clr_vs_new", ovf, 4'b0001);
      end
      ovf_clr = 1'b0;
      wait_idle(40, ok);
      chk("sat_drain", ok, 1);
      chk("sat_toggles", tog_cnt - base, 17);
      chk("sat_ovf_sticky", ovf, 4'b0001);
      chk("sat_q", q, 1);

      // reset mid-stream with 3 pulses queued on requester 1
      for (int k = 0; k < 8; k++) begin
         if (k != 6) req_t[1] = ~req_t[1];
         step();
      end
      chk("midrst_pre_q", q, 1);
      chk("midrst_pre_pending", pending, 4'b0010);
      chk("midrst_pre_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("midrst_q", q, 0);
      chk("midrst_pending", pending, 0);
      chk("midrst_ovf", ovf, 0);
      chk("midrst_busy", busy, 0);
      req_t = '0;
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk("postrst_q", q, 0);
      chk("postrst_pending", pending, 0);
      chk("postrst_busy", busy, 0);

      // back-to-back on requester 2 with MIN_GAP=1
      for (int k = 0; k < 5; k++) begin
         if (k < 3) req1_t[2] = ~req1_t[2];
         step();
         chk($sformatf("b2b%0d_q", k), q1, t3_q[k]);
         chk($sformatf("b2b%0d_pending", k), pending1, (k < 3) ? 4'b0100 : 4'b0000);
         chk($sformatf("b2b%0d_busy", k), busy1, t3_b[k]);
      end
      chk("b2b_ovf", ovf1, 0);

      // random pulse conservation
      base   = tog_cnt;
      pulses = 0;
      for (int n = 0; n < 10000; n++) begin
         chg = '0;
         for (int i = 0; i < 4; i++) if ($urandom_range(31) == 0) chg[i] = 1'b1;
         req_t  = req_t ^ chg;
         pulses += $countones(chg);
         step();
      end
      wait_idle(200, ok);
      chk("rand_drain", ok, 1);
      chk("rand_conserve", tog_cnt - base, pulses);
      chk("rand_no_ovf", ovf, 0);
      chk("min_gap", gap_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
